counter_bank: RTL and testbench

//   Parametrised bank of NUM_CH independent up/down modulo counters sharing one clock.

---
 rtl/counter_bank_pkg.sv | 29 ++
 rtl/counter_channel.sv | 82 ++++++++
 rtl/counter_bank.sv | 42 ++++
 tb/tb_counter_bank.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_bank_pkg: shared types for the counter bank (per-channel actions). |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package counter_bank_pkg;

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_CLR   = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_COUNT = 2'd3
  } ch_action_e;

  // Resolves the per-edge control priority: clear, then load, then count.
  function automatic ch_action_e sel_action(input logic clr, input logic load,
                                            input logic en);
    if (clr) begin
      return ACT_CLR;
    end else if (load) begin
      return ACT_LOAD;
    end else if (en) begin
      return ACT_COUNT;
    end
    return ACT_HOLD;
  endfunction

endpackage : counter_bank_pkg
`default_nettype wire

// File: rtl/counter_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_channel: one up/down modulo counter with clear, load and tc pulse. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module counter_channel
  import counter_bank_pkg::*;
#(
  parameter int          WIDTH   = 4,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_zero = '0;

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] w_load_clamped;
  ch_action_e       w_action;

  // A full-range limit can never be exceeded, so the clamp compare is elided.
  if (c_max == {WIDTH{1'b1}}) begin : g_no_clamp
    assign w_load_clamped = load_val;
  end else begin : g_clamp
    assign w_load_clamped = (load_val > c_max) ? c_max : load_val;
  end

  assign w_action = sel_action(clr, load, en);

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    unique case (w_action)
      ACT_CLR:  q_d = c_zero;
      ACT_LOAD: q_d = w_load_clamped;
      ACT_COUNT: begin
        if (dir) begin
          if (q_q == c_max) begin
            q_d  = c_zero;
            tc_d = 1'b1;
          end else begin
            q_d = q_q + c_one;
          end
        end else begin
          if (q_q == c_zero) begin
            q_d  = c_max;
            tc_d = 1'b1;
          end else begin
            q_d = q_q - c_one;
          end
        end
      end
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q  <= c_zero;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign q  = q_q;
  assign tc = tc_q;

endmodule : counter_channel
`default_nettype wire

// File: rtl/counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_bank: NUM_CH independent up/down modulo counters on one clock.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int          WIDTH   = 4,
  parameter int          NUM_CH  = 2,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  output logic [NUM_CH*WIDTH-1:0] q,
  output logic [NUM_CH-1:0]       tc
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_channel #(
      .WIDTH   (WIDTH),
      .MAX_VAL (MAX_VAL)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .dir      (dir[i]),
      .clr      (clr[i]),
      .load     (load[i]),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .q        (q[i*WIDTH +: WIDTH]),
      .tc       (tc[i])
    );
  end

endmodule : counter_bank
`default_nettype wire

// File: tb/tb_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_counter_bank: vector table, directed corners and random run vs a model. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_counter_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] en = '0, dir = '0, clr = '0, load = '0;
  logic [7:0] load_val = '0;
  logic [7:0] q_a, q_b;
  logic [1:0] tc_a, tc_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: dut_a wraps at 15, dut_b at 9.
  int ma[2];
  int mb[2];
  bit ta[2];
  bit tb[2];

  always #10 clk = ~clk;

  counter_bank #(.WIDTH(4), .NUM_CH(2), .MAX_VAL(15)) dut_a (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .q(q_a), .tc(tc_a)
  );

  counter_bank #(.WIDTH(4), .NUM_CH(2), .MAX_VAL(9)) dut_b (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .q(q_b), .tc(tc_b)
  );

  typedef struct {
    logic [1:0] en, dir, clr, load;
    logic [7:0] lv;
    logic [7:0] qa;
    logic [1:0] tca;
    logic [7:0] qb;
    logic [1:0] tcb;
  } vec_t;

  function automatic int nxt(input int q, input int maxv, input bit e, input bit d,
                             input bit c, input bit l, input int lv, output bit t);
    t = 1'b0;
    if (c) return 0;
    if (l) return (lv > maxv) ? maxv : lv;
    if (e) begin
      if (d) begin
        t = (q == maxv);
        return (q + 1) % (maxv + 1);
      end
      t = (q == 0);
      return (q + maxv) % (maxv + 1);
    end
    return q;
  endfunction

  task automatic model_update();
    for (int ch = 0; ch < 2; ch++) begin
      if (!rst) begin
        ma[ch] = 0; mb[ch] = 0; ta[ch] = 0; tb[ch] = 0;
      end else begin
        ma[ch] = nxt(ma[ch], 15, en[ch], dir[ch], clr[ch], load[ch],
                     int'(load_val[ch*4 +: 4]), ta[ch]);
        mb[ch] = nxt(mb[ch], 9, en[ch], dir[ch], clr[ch], load[ch],
                     int'(load_val[ch*4 +: 4]), tb[ch]);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, " q_a"},  q_a,  {4'(ma[1]), 4'(ma[0])});
    chk({nm, " tc_a"}, {6'd0, tc_a}, {6'd0, tb_bit(ta[1]), tb_bit(ta[0])});
    chk({nm, " q_b"},  q_b,  {4'(mb[1]), 4'(mb[0])});
    chk({nm, " tc_b"}, {6'd0, tc_b}, {6'd0, tb_bit(tb[1]), tb_bit(tb[0])});
  endtask

  function automatic logic tb_bit(input bit b);
    return logic'(b);
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    en = '0; dir = '0; clr = '0; load = '0; load_val = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_update();
    #1;
    chk_model("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h01, 2'b00, 8'h01, 2'b00};
    vecs[1]  = '{2'b10, 2'b00, 2'b00, 2'b00, 8'h00, 8'hF1, 2'b10, 8'h91, 2'b10};
    vecs[2]  = '{2'b01, 2'b01, 2'b00, 2'b01, 8'h0C, 8'hFC, 2'b00, 8'h99, 2'b00};
    vecs[3]  = '{2'b00, 2'b00, 2'b00, 2'b11, 8'hD3, 8'hD3, 2'b00, 8'h93, 2'b00};
    vecs[4]  = '{2'b11, 2'b11, 2'b00, 2'b00, 8'h00, 8'hE4, 2'b00, 8'h04, 2'b10};
    vecs[5]  = '{2'b11, 2'b11, 2'b00, 2'b00, 8'h00, 8'hF5, 2'b00, 8'h15, 2'b00};
    vecs[6]  = '{2'b11, 2'b11, 2'b00, 2'b00, 8'h00, 8'h06, 2'b10, 8'h26, 2'b00};
    vecs[7]  = '{2'b11, 2'b11, 2'b01, 2'b01, 8'h0A, 8'h10, 2'b00, 8'h30, 2'b00};
    vecs[8]  = '{2'b11, 2'b00, 2'b00, 2'b00, 8'h00, 8'h0F, 2'b01, 8'h29, 2'b01};
    vecs[9]  = '{2'b11, 2'b00, 2'b00, 2'b00, 8'h00, 8'hFE, 2'b10, 8'h18, 2'b00};
    vecs[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'hFE, 2'b00, 8'h18, 2'b00};
    vecs[11] = '{2'b00, 2'b00, 2'b11, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00};
    vecs[12] = '{2'b00, 2'b00, 2'b00, 2'b11, 8'h9F, 8'h9F, 2'b00, 8'h99, 2'b00};
    vecs[13] = '{2'b11, 2'b11, 2'b00, 2'b00, 8'h00, 8'hA0, 2'b01, 8'h00, 2'b11};

    // Reset held low, outputs must already be zero.
    rst = 1'b0;
    model_update();
    #100;
    chk_model("reset_hold");
    @(negedge clk);
    rst = 1'b1;

    // Channel 0 counts up for 20 edges; expected value is edge count mod 16.
    en = 2'b01; dir = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("up20 q0", {4'd0, q_a[3:0]}, 8'(k % 16));
      chk("up20 tc0", {7'd0, tc_a[0]}, {7'd0, k == 16});
      chk("up20 q1", {4'd0, q_a[7:4]}, 8'd0);
      chk_model("up20");
    end

    // Vector table from a clean reset.
    do_reset();
    foreach (vecs[i]) begin
      en = vecs[i].en; dir = vecs[i].dir; clr = vecs[i].clr;
      load = vecs[i].load; load_val = vecs[i].lv;
      step();
      chk($sformatf("vec%0d q_a", i),  q_a, vecs[i].qa);
      chk($sformatf("vec%0d tc_a", i), {6'd0, tc_a}, {6'd0, vecs[i].tca});
      chk($sformatf("vec%0d q_b", i),  q_b, vecs[i].qb);
      chk($sformatf("vec%0d tc_b", i), {6'd0, tc_b}, {6'd0, vecs[i].tcb});
    end

    // Direction flip on channel 0 starting from 5.
    do_reset();
    load = 2'b01; load_val = 8'h05; en = 2'b01; dir = 2'b01;
    step();
    load = 2'b00;
    chk("flip load", {4'd0, q_a[3:0]}, 8'd5);
    dir = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flip down", {4'd0, q_a[3:0]}, 8'(4 - k));
      chk_model("flip down");
    end
    dir = 2'b01;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("flip up", {4'd0, q_a[3:0]}, 8'(3 + k));
      chk_model("flip up");
    end

    // Asynchronous reset mid-cycle with q0=11, q1=3.
    idle_inputs();
    load = 2'b11; load_val = 8'h3B;
    step();
    load = 2'b00; en = 2'b11; dir = 2'b11;
    chk("pre_rst q_a", q_a, 8'h3B);
    @(posedge clk);
    model_update();
    #5;
    rst = 1'b0;
    model_update();
    #1;
    chk("async q_a", q_a, 8'h00);
    chk("async tc_a", {6'd0, tc_a}, 8'h00);
    chk("async q_b", q_b, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("resume q_a", q_a, 8'h11);
    chk_model("resume");

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      en = 2'($urandom);
      dir = 2'($urandom);
      clr = {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0};
      load = {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0};
      load_val = 8'($urandom);
      step();
      chk_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_counter_bank
`default_nettype wire
